cordic_iter_engine: RTL and testbench
=====================================

CORDIC_ITER_ENGINE -- requirements
Module: cordic_iter_engine

Interface
REQ-001 The block SHALL have parameter NUM_WIDTH, default 16, giving the two's-complement width of x, y and z.
REQ-002 The block SHALL have parameter ITERATIONS, default 14, legal range 1..NUM_WIDTH-2, giving the number of micro-rotations.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); sampled on accept.
REQ-006 The block SHALL have ports ix, iy and iz, input, NUM_WIDTH each: signed operands, sampled on accept.
REQ-007 The block SHALL have port in_valid, input, 1 bit: operands valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the engine can accept an operand.
REQ-009 The block SHALL have ports ox, oy and oz, output, NUM_WIDTH each: signed results.
REQ-010 The block SHALL have port out_valid, output, 1 bit: results valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the results.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The angle format SHALL scale z so that 2^(NUM_WIDTH-1) represents pi, with wrap-around modulo 2^NUM_WIDTH.
REQ-014 An internal constant table SHALL hold ATAN[i] = round(atan(2^-i) * 2^(NUM_WIDTH-1) / pi) for i = 0..ITERATIONS-1 (for NUM_WIDTH=16, ATAN[0] = 8192).
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; every other state SHALL hold in_ready at 0.
REQ-017 Accept SHALL occur on a clock edge where in_valid=1 and in_ready=1; on accept, ix/iy/iz/mode are registered, iteration counter i is set to 0, and the state becomes RUN.
REQ-018 Each RUN cycle SHALL perform one micro-rotation with direction d = +1 when (mode=0 and z>=0) or (mode=1 and y<0), else d = -1.
REQ-019 The micro-rotation update SHALL be x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*ATAN[i].
REQ-020 Shifts SHALL be arithmetic (sign-extending), and adds/subtracts SHALL be NUM_WIDTH-bit with silent wrap and no saturation.
REQ-021 When the update with i = ITERATIONS-1 completes, the state SHALL become DONE; otherwise i increments.
REQ-022 Latency SHALL be exactly ITERATIONS+1 rising edges from the accept edge to the first cycle with out_valid=1.
REQ-023 In DONE, out_valid SHALL be 1, and ox/oy/oz SHALL equal the final x/y/z and remain stable while out_ready=0.
REQ-024 In DONE with out_ready=1, the edge SHALL complete the transfer and the state becomes IDLE; there is no same-cycle re-accept, so the minimum issue interval is ITERATIONS+2 cycles.
REQ-025 out_valid SHALL be 0 in IDLE and RUN.
REQ-026 ox/oy/oz SHALL hold their last delivered values outside DONE.
REQ-027 CORDIC gain SHALL NOT be compensated: magnitudes are scaled by K ≈ 1.6468 for large ITERATIONS.
REQ-028 in_valid during RUN or DONE SHALL be ignored, with no effect on the running operation.

Reset
REQ-029 On any clock edge with rst=1, the state SHALL become IDLE, i=0, ox=oy=oz=0, out_valid=0 and busy=0, with in_ready=1 from the following cycle.
REQ-030 Reset SHALL take priority over accept and over transfer in the same cycle.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation, and no result is ever presented for it.

Verification (NUM_WIDTH=16, ITERATIONS=14)
REQ-032 The bench SHALL check rotation: mode=0, ix=10000, iy=0, iz=0 -> out_valid exactly 15 edges after accept, ox=16468±4, oy=0±4, oz=0±2.
REQ-033 The bench SHALL check a quarter-turn: mode=0, ix=10000, iy=0, iz=16384 -> ox=0±4, oy=16468±4.
REQ-034 The bench SHALL check vectoring: mode=1, ix=10000, iy=10000, iz=0 -> ox=23289±6, oy=0±4, oz=8192±2.
REQ-035 The bench SHALL check backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs unchanged, in_ready stays 0, and a pulsed in_valid is ignored.
REQ-036 The bench SHALL check reset mid-RUN: assert rst at the 6th RUN cycle -> next cycle all outputs 0, in_ready=1, and a subsequent operand from REQ-032 yields the REQ-032 result.
REQ-037 The bench SHALL check back-to-back operation: in_valid held high with out_ready=1 -> accepts spaced exactly 16 cycles apart, with results in order.

Source files
------------

// File: rtl/cordic_if.sv
// cordic_if: operand/result handshake bundle for the iterative CORDIC engine.
interface cordic_if #(parameter int NUM_WIDTH = 16);
    logic mode, in_valid, in_ready, out_valid, out_ready, busy;
    logic signed [NUM_WIDTH-1:0] ix, iy, iz, ox, oy, oz;
    modport master (
        output mode, ix, iy, iz, in_valid, out_ready,
        input  in_ready, ox, oy, oz, out_valid, busy
    );
    modport slave (
        input  mode, ix, iy, iz, in_valid, out_ready,
        output in_ready, ox, oy, oz, out_valid, busy
    );
endinterface

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: one micro-rotation per cycle, uncompensated gain, pi = 2^(NUM_WIDTH-1).
module cordic_iter_engine #(
    parameter int NUM_WIDTH  = 16,
    parameter int ITERATIONS = 14
) (
    input logic clk,
    input logic rst,
    cordic_if.slave io
);
    localparam int W  = NUM_WIDTH;
    localparam int IW = $clog2(ITERATIONS + 1);
    localparam int SH = 32 - NUM_WIDTH;
    // atan(2^-i) with pi = 2^31; narrower widths round this down to W bits
    localparam logic [31:0] ATAN32 [32] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };
    function automatic logic [W-1:0] atan_c(input int k);
        logic [63:0] v;
        v = {32'd0, ATAN32[k]};
        v = ((v << 1) + (64'd1 << SH)) >> (SH + 1);
        return v[W-1:0];
    endfunction
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t st;
    logic signed [W-1:0] x, y, z, xs, ys, xn, yn, zn, ang;
    logic md, dp;
    logic [IW-1:0] i;
    always_comb begin
        ang = '0;
        for (int k = 0; k < ITERATIONS; k++)
            if (i == IW'(k)) ang = atan_c(k);
        dp = md ? y[W-1] : ~z[W-1];
        xs = x >>> i;
        ys = y >>> i;
        xn = dp ? x - ys : x + ys;
        yn = dp ? y + xs : y - xs;
        zn = dp ? z - ang : z + ang;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= IDLE;
            i            <= '0;
            io.ox        <= '0;
            io.oy        <= '0;
            io.oz        <= '0;
            io.out_valid <= 1'b0;
            io.busy      <= 1'b0;
            io.in_ready  <= 1'b1;
        end else begin
            case (st)
                IDLE: if (io.in_valid && io.in_ready) begin
                    x           <= io.ix;
                    y           <= io.iy;
                    z           <= io.iz;
                    md          <= io.mode;
                    i           <= '0;
                    st          <= RUN;
                    io.in_ready <= 1'b0;
                    io.busy     <= 1'b1;
                end
                RUN: begin
                    x <= xn;
                    y <= yn;
                    z <= zn;
                    if (i == IW'(ITERATIONS - 1)) begin
                        st           <= DONE;
                        io.out_valid <= 1'b1;
                        io.ox        <= xn;
                        io.oy        <= yn;
                        io.oz        <= zn;
                    end else i <= i + 1'b1;
                end
                DONE: if (io.out_ready) begin
                    st           <= IDLE;
                    io.out_valid <= 1'b0;
                    io.busy      <= 1'b0;
                    io.in_ready  <= 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: directed and random checks against a plain-arithmetic CORDIC model.
module tb_cordic_iter_engine;
    localparam int W = 16;
    localparam int N = 14;
    logic clk = 1'b0, rst = 1'b1;
    int total = 0, bad = 0;
    int atan_m [N];
    cordic_if #(.NUM_WIDTH(W)) bus ();
    cordic_iter_engine #(.NUM_WIDTH(W), .ITERATIONS(N)) dut (.clk(clk), .rst(rst), .io(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        total++;
        if (got - exp > tol || exp - got > tol) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic m, input int x0, input int y0, input int z0,
                                  output int rx, output int ry, output int rz);
        logic signed [W-1:0] x, y, z, nx, ny;
        int d;
        x = W'(x0); y = W'(y0); z = W'(z0);
        for (int k = 0; k < N; k++) begin
            d  = ((!m && z >= 0) || (m && y < 0)) ? 1 : -1;
            nx = W'(int'(x) - d * (int'(y) >>> k));
            ny = W'(int'(y) + d * (int'(x) >>> k));
            z  = W'(int'(z) - d * atan_m[k]);
            x = nx; y = ny;
        end
        rx = int'(x); ry = int'(y); rz = int'(z);
    endfunction

    task automatic run_op(input string tag, input logic m, input int x0, input int y0, input int z0,
                          output int rx, output int ry, output int rz);
        int lat, w;
        bus.mode = m; bus.ix = W'(x0); bus.iy = W'(y0); bus.iz = W'(z0);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin tick(); w++; end
        chk({tag, "_ready"}, int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 60) begin tick(); lat++; end
        chk({tag, "_lat"}, lat, N + 1);
        rx = int'(bus.ox); ry = int'(bus.oy); rz = int'(bus.oz);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int rx, ry, rz, ex, ey, ez, hx, hy, hz, lat, cyc, last, nacc, got;
        logic m;
        int qx[$], qy[$], qz[$];
        for (int k = 0; k < N; k++)
            atan_m[k] = int'($floor($atan(2.0 ** (-k)) * 32768.0 / 3.14159265358979 + 0.5));
        bus.mode = 1'b0; bus.ix = '0; bus.iy = '0; bus.iz = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ox", int'(bus.ox), 0);
        chk("rst_oy", int'(bus.oy), 0);
        chk("rst_oz", int'(bus.oz), 0);
        chk("atan0", atan_m[0], 8192);

        run_op("rot", 1'b0, 10000, 0, 0, rx, ry, rz);
        chk("rot_ox", rx, 16468, 4); chk("rot_oy", ry, 0, 4); chk("rot_oz", rz, 0, 2);
        run_op("quarter", 1'b0, 10000, 0, 16384, rx, ry, rz);
        chk("quarter_ox", rx, 0, 4); chk("quarter_oy", ry, 16468, 4);
        model(1'b0, 10000, 0, 16384, ex, ey, ez);
        chk("quarter_oz_model", rz, ez);
        run_op("vec", 1'b1, 10000, 10000, 0, rx, ry, rz);
        chk("vec_ox", rx, 23289, 6); chk("vec_oy", ry, 0, 4); chk("vec_oz", rz, 8192, 2);

        for (int t = 0; t < 20; t++) begin
            m = 1'(t % 2);
            hx = $urandom_range(65535) - 32768;
            hy = $urandom_range(65535) - 32768;
            hz = $urandom_range(65535) - 32768;
            if (t >= 16) begin hx = hx / 4; hy = hy / 4; end
            run_op("rand", m, hx, hy, hz, rx, ry, rz);
            model(m, hx, hy, hz, ex, ey, ez);
            chk("rand_ox", rx, ex); chk("rand_oy", ry, ey); chk("rand_oz", rz, ez);
        end

        bus.mode = 1'b0; bus.ix = 16'sd3000; bus.iy = -16'sd2000; bus.iz = 16'sd5000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 60) begin tick(); lat++; end
        chk("bp_lat", lat, N + 1);
        hx = int'(bus.ox); hy = int'(bus.oy); hz = int'(bus.oz);
        model(1'b0, 3000, -2000, 5000, ex, ey, ez);
        chk("bp_ox", hx, ex); chk("bp_oy", hy, ey); chk("bp_oz", hz, ez);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'(c % 2); bus.ix = 16'sd1234; bus.iz = -16'sd999; bus.mode = 1'b1;
            tick();
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_hold_ox", int'(bus.ox), hx);
            chk("bp_hold_oy", int'(bus.oy), hy);
            chk("bp_hold_oz", int'(bus.oz), hz);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release_valid", int'(bus.out_valid), 0);
        chk("bp_release_ready", int'(bus.in_ready), 1);
        chk("bp_keep_ox", int'(bus.ox), hx);

        bus.mode = 1'b1; bus.ix = 16'sd7000; bus.iy = 16'sd4000; bus.iz = 16'sd0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ox", int'(bus.ox), 0);
        chk("abort_oy", int'(bus.oy), 0);
        chk("abort_oz", int'(bus.oz), 0);
        chk("abort_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_ready", int'(bus.in_ready), 1);
        got = 0;
        repeat (20) begin tick(); got += int'(bus.out_valid); end
        chk("abort_no_result", got, 0);
        run_op("post_abort", 1'b0, 10000, 0, 0, rx, ry, rz);
        chk("post_abort_ox", rx, 16468, 4); chk("post_abort_oy", ry, 0, 4); chk("post_abort_oz", rz, 0, 2);

        // Feed a fresh operand right after each accept; results must come back in order.
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.mode = 1'($urandom_range(1));
        bus.ix = W'($urandom_range(16383)); bus.iy = W'($urandom_range(16383)); bus.iz = W'($urandom);
        cyc = 0; last = -1; nacc = 0; got = 0;
        while (got < 6 && cyc < 300) begin
            m = bus.in_valid && bus.in_ready;
            if (m) begin
                if (last >= 0) chk("b2b_gap", cyc - last, N + 2);
                last = cyc;
                model(bus.mode, int'(bus.ix), int'(bus.iy), int'(bus.iz), ex, ey, ez);
                qx.push_back(ex); qy.push_back(ey); qz.push_back(ez);
                nacc++;
            end
            if (bus.out_valid) begin
                if (qx.size() > 0) begin
                    chk("b2b_ox", int'(bus.ox), qx.pop_front());
                    chk("b2b_oy", int'(bus.oy), qy.pop_front());
                    chk("b2b_oz", int'(bus.oz), qz.pop_front());
                end else chk("b2b_spurious", 1, 0);
                got++;
            end
            tick();
            cyc++;
            if (m) begin
                bus.mode = 1'($urandom_range(1));
                bus.ix = W'($urandom_range(16383)); bus.iy = W'($urandom_range(16383)); bus.iz = W'($urandom);
                if (nacc == 6) bus.in_valid = 1'b0;
            end
        end
        chk("b2b_count", got, 6);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
